fetch_stage: RTL

- IF stage of the sequential RISC-V core. Owns the 64-bit PC register and drives it to the combinational instruction memory.
- Captures the returned 32-bit word into an IF/ID output register, with a valid/ready handshake toward decode.
- Accepts a redirect from the branch resolution logic, which flushes the output register.
- Detects misaligned redirect targets and parks in a fault state.

---
 rtl/core_pkg.sv | 15 +
 rtl/branch_predict_static.sv | 24 ++
 rtl/fetch_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the sequential RISC-V core: datapath width, the
// canonical NOP encoding, opcode constants and the fetch FSM state type.
package core_pkg;

    localparam int          XLEN       = 64;
    localparam logic [31:0] INSTR_NOP  = 32'h00000013;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/branch_predict_static.sv
// Static backward-taken/forward-not-taken predictor for conditional branches.
// Purely combinational: decodes the B-type immediate of the fetched word.
module branch_predict_static #(
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o
);
    import core_pkg::*;

    logic [XLEN-1:0] b_offset;
    logic            unused_instr_bits;

    // B-immediate: instr[31] is imm[12] and doubles as the sign bit.
    assign b_offset = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25],
                       instr_i[11:8], 1'b0};

    assign taken_o           = (instr_i[6:0] == OPC_BRANCH) && instr_i[31];
    assign target_o          = pc_i + b_offset;
    assign unused_instr_bits = ^instr_i[24:12];

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches from combinational instruction memory and
// holds the IF/ID register. Define FETCH_STATIC_PREDICT_EN for static prediction.
module fetch_stage #(
    parameter int              XLEN            = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              IMEM_INDEX_BITS = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_pc,
    input  logic [31:0]     imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            if_pred_taken,
    output logic            fetch_fault,
    output logic [31:0]     fetch_count
);
    import core_pkg::*;

    if (IMEM_INDEX_BITS < 1 || IMEM_INDEX_BITS > XLEN - 2) begin : g_bad_index
        $error("IMEM_INDEX_BITS must fit inside the PC above the byte offset");
    end

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic            if_pred_q, if_pred_d;
    logic [31:0]     fetch_count_q, fetch_count_d;

    logic            transfer;
    logic            capture_taken;
    logic [XLEN-1:0] next_pc;

`ifdef FETCH_STATIC_PREDICT_EN
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    branch_predict_static #(
        .XLEN     (XLEN)
    ) u_branch_predict (
        .pc_i     (pc_q),
        .instr_i  (imem_instr),
        .taken_o  (pred_taken),
        .target_o (pred_target)
    );

    assign capture_taken = pred_taken;
    assign next_pc       = pred_taken ? pred_target : pc_q + XLEN'(4);
`else
    assign capture_taken = 1'b0;
    assign next_pc       = pc_q + XLEN'(4);
`endif

    // A transfer completes whenever decode sees a valid word it can accept,
    // even if a redirect flushes the register in the same cycle.
    assign transfer = if_valid_q & id_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so that no
        // path through the case/if tree leaves one unassigned (no latches).
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_pred_d     = if_pred_q;
        fetch_count_d = fetch_count_q + 32'(transfer);

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    state_d    = S_FAULT;
                    if_valid_d = 1'b0;
                end else if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                end else if (!if_valid_q || id_ready) begin
                    if_instr_d = imem_instr;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    if_pred_d  = capture_taken;
                    pc_d       = next_pc;
                end
            end
            S_FAULT: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d    = S_FAULT;
                if_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= INSTR_NOP;
            if_pred_q     <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_pred_q     <= if_pred_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_pc       = pc_q;
    assign if_valid      = if_valid_q;
    assign if_pc         = if_pc_q;
    assign if_instr      = if_instr_q;
    assign if_pred_taken = if_pred_q;
    assign fetch_fault   = (state_q == S_FAULT);
    assign fetch_count   = fetch_count_q;

endmodule
